// File: rtl/uarc_recv_port.sv
// Receive port: arbitrates kill/incept/stream/send requests from the bus into a send FIFO
// and an incept register. Optional permission filter enabled by UARC_RECV_PERM_CHECK_EN.
module uarc_recv_port #(
    parameter int unsigned WORD_MAG = 5,
    parameter int unsigned FIFO_MAG = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bus_enable,
    input  logic                       bus_kill,
    input  logic                       bus_incept,
    input  logic                       bus_send,
    input  logic                       bus_stream,
    input  logic [(1<<WORD_MAG)-1:0]   bus_data,
    input  logic [(1<<WORD_MAG)-1:0]   bus_self_permission,
    input  logic [(1<<WORD_MAG)-1:0]   bus_self_address,
    input  logic [(1<<WORD_MAG)-1:0]   bus_incept_permission,
    input  logic [(1<<WORD_MAG)-1:0]   bus_incept_address,
    output logic                       bus_kill_ack,
    output logic                       bus_incept_ack,
    output logic                       bus_send_ack,
    output logic                       bus_stream_ack,
    input  logic [(1<<WORD_MAG)-1:0]   core_self_address,
    output logic                       core_send_valid,
    output logic [(1<<WORD_MAG)-1:0]   core_send_data,
    output logic                       core_send_is_stream,
    input  logic                       core_send_take,
    output logic                       core_incept_valid,
    output logic [(1<<WORD_MAG)-1:0]   core_incept_permission,
    output logic [(1<<WORD_MAG)-1:0]   core_incept_address,
    input  logic                       core_incept_take,
    output logic                       core_kill,
    output logic                       core_reject
);

    localparam int unsigned W = 1 << WORD_MAG;
    localparam int unsigned D = 1 << FIFO_MAG;
    localparam logic [FIFO_MAG:0] DEPTH = (FIFO_MAG + 1)'(D);

    typedef enum logic [1:0] {StIdle, StStream, StKilled} state_e;

    state_e              state_q, state_d;
    logic [W:0]          mem_q [D];
    logic [FIFO_MAG-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_MAG:0]   count_q;
    logic                inc_valid_q;
    logic [W-1:0]        inc_perm_q, inc_addr_q;
    logic                kill_q;

    logic active, not_full, not_empty, pop, push, word_ack, perm_ok;

    // Reset gates every ack so nothing is accepted while the port is held in reset.
    assign active    = reset & bus_enable & (state_q != StKilled);
    assign not_full  = count_q < DEPTH;
    assign not_empty = count_q != '0;

    assign bus_kill_ack   = active & bus_kill;
    assign bus_incept_ack = active & ~bus_kill & bus_incept & (~inc_valid_q | core_incept_take);
    assign bus_stream_ack = active & ~bus_kill & ~bus_incept_ack & bus_stream & not_full;
    assign bus_send_ack   = active & ~bus_kill & ~bus_incept_ack & ~bus_stream & bus_send &
                            not_full & (state_q == StIdle);

`ifdef UARC_RECV_PERM_CHECK_EN
    logic reject_q;

    assign perm_ok = ((bus_self_address ^ core_self_address) & bus_self_permission) == '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reject_q <= 1'b0;
        end else begin
            reject_q <= word_ack & ~perm_ok;
        end
    end

    assign core_reject = reject_q;
`else
    logic unused_perm;

    assign unused_perm = ^{bus_self_address, bus_self_permission, core_self_address};
    assign perm_ok     = 1'b1;
    assign core_reject = 1'b0;
`endif

    assign word_ack = bus_stream_ack | bus_send_ack;
    assign push     = word_ack & perm_ok;
    assign pop      = core_send_take & not_empty;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus_stream_ack) state_d = StStream;
            StStream: if (!bus_stream || !bus_enable) state_d = StIdle;
            StKilled: if (!bus_kill) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (bus_kill_ack) state_d = StKilled;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Kill wins over any pop or push in the same cycle: the queue simply empties.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus_kill_ack) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_MAG'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_MAG'(1);
            count_q <= count_q + (FIFO_MAG + 1)'(push) - (FIFO_MAG + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus_stream_ack, bus_data};
    end

    assign core_send_valid     = not_empty;
    assign core_send_data      = not_empty ? mem_q[rd_ptr_q][W-1:0] : '0;
    assign core_send_is_stream = not_empty & mem_q[rd_ptr_q][W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_valid_q <= 1'b0;
            inc_perm_q  <= '0;
            inc_addr_q  <= '0;
            kill_q      <= 1'b0;
        end else begin
            kill_q <= bus_kill_ack;
            if (bus_kill_ack) begin
                inc_valid_q <= 1'b0;
            end else if (bus_incept_ack) begin
                inc_valid_q <= 1'b1;
                inc_perm_q  <= bus_incept_permission;
                inc_addr_q  <= bus_incept_address;
            end else if (core_incept_take) begin
                inc_valid_q <= 1'b0;
            end
        end
    end

    assign core_incept_valid      = inc_valid_q;
    assign core_incept_permission = inc_perm_q;
    assign core_incept_address    = inc_addr_q;
    assign core_kill              = kill_q;

endmodule

// File: doc/uarc_recv_port.md
UARC_RECV_PORT -- requirements
Module: uarc_recv_port

Interface
REQ-001 Parameter WORD_MAG, default 5, sets word width W = 1<<WORD_MAG.
REQ-002 Parameter FIFO_MAG, default 2, sets send FIFO depth D = 1<<FIFO_MAG.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 bus_enable  in  1  sender has selected this port.
REQ-006 bus_kill, bus_incept, bus_send, bus_stream  in  1 each  level-held requests from the sender.
REQ-007 bus_data, bus_self_permission, bus_self_address, bus_incept_permission, bus_incept_address  in  W each  bus payload.
REQ-008 bus_kill_ack, bus_incept_ack, bus_send_ack, bus_stream_ack  out  1 each  combinational accept strobes.
REQ-009 core_self_address  in  W  this core's address (used only under REQ-030).
REQ-010 core_send_valid  out  1  FIFO not empty.
REQ-011 core_send_data  out  W  FIFO head word.
REQ-012 core_send_is_stream  out  1  FIFO head came from a stream.
REQ-013 core_send_take  in  1  pop FIFO head.
REQ-014 core_incept_valid  out  1  incept register full.
REQ-015 core_incept_permission, core_incept_address  out  W each  held incept payload.
REQ-016 core_incept_take  in  1  clear incept register.
REQ-017 core_kill  out  1  one-cycle kill pulse to the core.
REQ-018 core_reject  out  1  one-cycle pulse when a word is discarded per REQ-030.

Function
REQ-019 Acks are combinational; a transfer occurs in every cycle its ack is high, and the sender advances on ack.
REQ-020 With bus_enable low, all acks are 0 and nothing is accepted.
REQ-021 Priority: kill > incept > stream > send; at most one ack is high per cycle.
REQ-022 Kill: bus_kill_ack = bus_enable & bus_kill, always accepted; on acceptance the FIFO and incept register are flushed, core_kill pulses next cycle, state goes to KILLED.
REQ-023 FSM states IDLE, STREAM, KILLED; KILLED -> IDLE on the first cycle bus_kill is low; all acks are 0 in KILLED.
REQ-024 Incept: acked when the incept register is empty (or core_incept_take is high in the same cycle) and no kill; the payload is latched and core_incept_valid is set next cycle.
REQ-025 Stream: in IDLE, bus_stream with count < D is acked and the word is pushed with tag 1; state goes to STREAM. In STREAM, one word is accepted per cycle while count < D. STREAM -> IDLE when bus_stream or bus_enable is low.
REQ-026 Send: in IDLE only, acked when count < D; the word is pushed with tag 0; one word per request.
REQ-027 Full rule: a push requires count < D at the start of the cycle; there is no pass-through when full, even if core_send_take is high.
REQ-028 Simultaneous push and pop leaves count unchanged; core_send_take with an empty FIFO is ignored; pointers wrap modulo D.
REQ-029 Kill in the same cycle as a pop or incept_take results in an empty FIFO and an empty incept register.

Configuration
REQ-030 Macro UARC_RECV_PERM_CHECK_EN. When defined, a send or stream word is accepted only if ((bus_self_address ^ core_self_address) & bus_self_permission) == 0. A failing word is still acked but is not pushed, and core_reject pulses next cycle. When undefined, all words are pushed, core_reject is tied 0, and core_self_address is unused.

Reset
REQ-031 Reset low asynchronously clears the FIFO (count 0, pointers 0), the incept register, the FSM (to IDLE), core_kill and core_reject.
REQ-032 During reset all acks are 0 and core_send_valid = core_incept_valid = 0; payload outputs are 0.
REQ-033 Reset asserted mid-stream aborts the stream; the partial words are lost.

Verification
REQ-034 D=4: send 0xA1, 0xB2, 0xC3, 0xD4 with no pops, then a fifth send -> four acks, fifth ack held 0; one core_send_take -> fifth acked next cycle.
REQ-035 Stream 6 words with core_send_take held high -> continuous acks, FIFO order preserved, core_send_is_stream = 1, FSM returns to IDLE when bus_stream drops.
REQ-036 Incept (perm 0xF0, addr 0x12) while incept_valid=1 -> no ack until core_incept_take; the latched payload matches the bus payload.
REQ-037 Kill with 3 words queued plus a pending incept -> kill_ack the same cycle, core_kill a one-cycle pulse, core_send_valid = core_incept_valid = 0; no acks until bus_kill drops.
REQ-038 With UARC_RECV_PERM_CHECK_EN, core_self_address=0x10, send addr 0x11 perm 0x0F -> ack, no push, core_reject pulse; with addr 0x30 perm 0x0F -> pushed.
